// File: rtl/gate_ex_pkg.sv
// Shared types and constants for the gate exerciser.
// FSM encoding, vector count and settle-time bounds.
package gate_ex_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    localparam int NUM_VEC    = 4;
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;

    // Keep the settle time inside what the 4-bit counter can count.
    function automatic int settle_clamp(input int v);
        if (v < SETTLE_MIN) return SETTLE_MIN;
        if (v > SETTLE_MAX) return SETTLE_MAX;
        return v;
    endfunction

endpackage

// File: rtl/gate_ex_golden.sv
// Expected-value model of the gate unit under test.
// Purely combinational: AND, OR and NOT-of-a.
module gate_ex_golden (
    input  logic a_i,
    input  logic b_i,
    output logic and_o,
    output logic or_o,
    output logic not_o
);

    // Reference responses for one stimulus pair.
    always_comb begin
        and_o = a_i & b_i;
        or_o  = a_i | b_i;
        not_o = ~a_i;
    end

endmodule

// File: rtl/gate_exerciser.sv
// Walks all four (a,b) vectors through an external gate unit
// and records which vectors produced a wrong response.
module gate_exerciser
    import gate_ex_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       start_in,
    output logic       a_out,
    output logic       b_out,
    input  logic       y_and_in,
    input  logic       y_or_in,
    input  logic       y_not_in,
    output logic       busy_out,
    output logic       done_out,
    output logic       pass_out,
    output logic [2:0] err_count_out,
    output logic [3:0] fail_vec_out
);

    localparam int         SETTLE_EFF  = settle_clamp(SETTLE_CYCLES);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_EFF - 1);
    localparam logic [1:0] LAST_IDX    = 2'(NUM_VEC - 1);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] settle_q, settle_d;
    logic [2:0] err_q, err_d;
    logic [3:0] fail_q, fail_d;
    logic       pass_q, pass_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic exp_and, exp_or, exp_not;
    logic mismatch;

    gate_ex_golden u_golden (
        .a_i   (idx_q[1]),
        .b_i   (idx_q[0]),
        .and_o (exp_and),
        .or_o  (exp_or),
        .not_o (exp_not)
    );

    assign mismatch = (y_and_in != exp_and)
                    | (y_or_in  != exp_or)
                    | (y_not_in != exp_not);

    // State register; reset overrides everything, including a start.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            fail_q   <= '0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
            pass_q   <= pass_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: settle, sample, step to the next vector.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        err_d    = err_q;
        fail_d   = fail_q;
        pass_d   = pass_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    state_d  = ST_APPLY;
                    idx_d    = '0;
                    settle_d = '0;
                    err_d    = '0;
                    fail_d   = '0;
                    pass_d   = 1'b0;
                end
            end
            ST_APPLY: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = ST_SAMPLE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    fail_d = fail_q | 4'(4'b0001 << idx_q);
                    err_d  = err_q + 3'd1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    pass_d  = (err_d == 3'd0);
                end else begin
                    state_d = ST_APPLY;
                    idx_d   = idx_q + 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_APPLY) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
    end

    // Output decode: stimulus only while a vector is being exercised.
    always_comb begin
        a_out = 1'b0;
        b_out = 1'b0;
        if (state_q == ST_APPLY || state_q == ST_SAMPLE) begin
            a_out = idx_q[1];
            b_out = idx_q[0];
        end
    end

    assign busy_out      = busy_q;
    assign done_out      = done_q;
    assign pass_out      = pass_q;
    assign err_count_out = err_q;
    assign fail_vec_out  = fail_q;

endmodule
